alu_sub_serial: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_sub_serial_digit_sub.sv | 21 ++
 rtl/alu_sub_serial.sv | 121 ++++++++++++
 tb/tb_alu_sub_serial.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the digit-serial ALU subtractor: FSM states, default digit width
// and the digit-count helper.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int DIGIT_WIDTH_DEFAULT = 4;

   function automatic int num_digits(input int word_w, input int digit_w);
      return word_w / digit_w;
   endfunction

endpackage

// File: rtl/alu_sub_serial_digit_sub.sv
// Combinational DIGIT_WIDTH-bit subtractor: d = a - b - bin, bout set when the digit borrows.
module digit_sub
   import alu_pkg::*;
#(
   parameter int DIGIT_WIDTH = DIGIT_WIDTH_DEFAULT
) (
   input  logic [DIGIT_WIDTH-1:0] a,
   input  logic [DIGIT_WIDTH-1:0] b,
   input  logic                   bin,
   output logic [DIGIT_WIDTH-1:0] d,
   output logic                   bout
);

   logic [DIGIT_WIDTH:0] full;

   // One extra bit catches the borrow as the sign of the widened difference.
   assign full = {1'b0, a} - {1'b0, b} - {{DIGIT_WIDTH{1'b0}}, bin};
   assign d    = full[DIGIT_WIDTH-1:0];
   assign bout = full[DIGIT_WIDTH];

endmodule

// File: rtl/alu_sub_serial.sv
// Digit-serial subtractor diff = a - b - bin, LSB digit first, borrow chained through a register.
// Optional macro ALU_SUB_SAT_EN: unsigned saturation to zero when the final borrow is set.
module alu_sub_serial
   import alu_pkg::*;
#(
   parameter int WORD_WIDTH  = 32,
   parameter int DIGIT_WIDTH = DIGIT_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] a,
   input  logic [WORD_WIDTH-1:0] b,
   input  logic                  bin,
   output logic                  ready,
   output logic                  done,
   output logic [WORD_WIDTH-1:0] diff,
   output logic                  bout,
   output logic                  zero
);

   localparam int NUM_DIGITS = num_digits(WORD_WIDTH, DIGIT_WIDTH);
   localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

   state_t                  state;
   logic [WORD_WIDTH-1:0]   a_sr;
   logic [WORD_WIDTH-1:0]   b_sr;
   logic [WORD_WIDTH-1:0]   diff_sr;
   logic                    borrow;
   logic [CNT_W-1:0]        count;

   logic [DIGIT_WIDTH-1:0]  digit_d;
   logic                    digit_bout;
   logic [WORD_WIDTH-1:0]   digit_ext;
   logic [WORD_WIDTH-1:0]   diff_next;
   logic [WORD_WIDTH-1:0]   result_next;

   digit_sub #(
      .DIGIT_WIDTH(DIGIT_WIDTH)
   ) u_digit_sub (
      .a   (a_sr[DIGIT_WIDTH-1:0]),
      .b   (b_sr[DIGIT_WIDTH-1:0]),
      .bin (borrow),
      .d   (digit_d),
      .bout(digit_bout)
   );

   // New digit enters at the MS end so the LSB digit ends up at the bottom after the last shift.
   assign digit_ext = WORD_WIDTH'(digit_d);
   assign diff_next = (diff_sr >> DIGIT_WIDTH) | (digit_ext << (WORD_WIDTH - DIGIT_WIDTH));

`ifdef ALU_SUB_SAT_EN
   assign result_next = digit_bout ? '0 : diff_next;
`else
   assign result_next = diff_next;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ready   <= 1'b1;
         done    <= 1'b0;
         diff    <= '0;
         bout    <= 1'b0;
         zero    <= 1'b1;
         a_sr    <= '0;
         b_sr    <= '0;
         diff_sr <= '0;
         borrow  <= 1'b0;
         count   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  borrow <= bin;
                  count  <= '0;
                  ready  <= 1'b0;
                  state  <= RUN;
               end
            end
            RUN: begin
               diff_sr <= diff_next;
               borrow  <= digit_bout;
               a_sr    <= a_sr >> DIGIT_WIDTH;
               b_sr    <= b_sr >> DIGIT_WIDTH;
               count   <= count + 1'b1;
               // Outputs change only here, so partial results never reach diff/bout/zero.
               if (count == LAST_DIGIT) begin
                  diff  <= result_next;
                  bout  <= digit_bout;
                  zero  <= (result_next == '0);
                  done  <= 1'b1;
                  ready <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  borrow <= bin;
                  count  <= '0;
                  ready  <= 1'b0;
                  state  <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sub_serial.sv
// Self-checking bench for alu_sub_serial: directed vectors, back-to-back, mid-run reset and
// random operations against a word-wide reference; honours ALU_SUB_SAT_EN.
module tb_alu_sub_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        bin;
   logic        ready;
   logic        done;
   logic [31:0] diff;
   logic        bout;
   logic        zero;

   int tests = 0;
   int fails = 0;

   alu_sub_serial #(
      .WORD_WIDTH (32),
      .DIGIT_WIDTH(4)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .bin  (bin),
      .ready(ready),
      .done (done),
      .diff (diff),
      .bout (bout),
      .zero (zero)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for ready, then presents one start pulse; returns just after the accept edge.
   task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic bi);
      int w = 0;
      while (!ready && w < 20) begin
         tick();
         w++;
      end
      if (!ready) checkOutput("ready_wait", 32'(ready), 32'd1);
      a     = av;
      b     = bv;
      bin   = bi;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic waitDone(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!done && cyc < 20);
   endtask

   task automatic checkResult(input string tag, input logic [31:0] ed, input logic eb, input logic ez);
      checkOutput({tag, "_diff"}, diff, ed);
      checkOutput({tag, "_bout"}, 32'(bout), 32'(eb));
      checkOutput({tag, "_zero"}, 32'(zero), 32'(ez));
   endtask

   task automatic runCheck(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic bi, input logic [31:0] ed, input logic eb, input logic ez);
      int cyc;
      applyStimulus(av, bv, bi);
      waitDone(cyc);
      checkOutput({tag, "_latency"}, 32'(cyc), 32'd8);
      checkResult(tag, ed, eb, ez);
   endtask

   function automatic logic [33:0] refModel(input logic [31:0] av, input logic [31:0] bv,
                                            input logic bi);
      logic [32:0] wide;
      logic [31:0] res;
      logic        bo;
      wide = {1'b0, av} - {1'b0, bv} - 33'(bi);
      bo   = wide[32];
      res  = wide[31:0];
`ifdef ALU_SUB_SAT_EN
      if (bo) res = 32'd0;
`endif
      return {bo, (res == 32'd0), res};
   endfunction

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          cyc;
      int          seen;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rbi;
      logic [33:0] m;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      tick();
      tick();
      checkOutput("rst_ready", 32'(ready), 32'd1);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkResult("rst", 32'd0, 1'b0, 1'b1);
      rst = 1'b0;
      tick();

      // 5 - 3, plus single-cycle done pulse
      runCheck("sub_5_3", 32'h5, 32'h3, 1'b0, 32'h2, 1'b0, 1'b0);
      checkOutput("sub_5_3_ready", 32'(ready), 32'd1);
      tick();
      checkOutput("done_pulse", 32'(done), 32'd0);
      checkResult("hold_idle", 32'h2, 1'b0, 1'b0);

`ifdef ALU_SUB_SAT_EN
      runCheck("sub_0_1", 32'h0, 32'h1, 1'b0, 32'h0, 1'b1, 1'b1);
`else
      runCheck("sub_0_1", 32'h0, 32'h1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
`endif
      runCheck("digit_borrow", 32'h10, 32'hF, 1'b1, 32'h0, 1'b0, 1'b1);

      // Back-to-back with start held high; operand changes during RUN must be ignored
      applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0);
      a     = 32'hFFFF_FFFF;
      b     = 32'hFFFF_FFFF;
      bin   = 1'b0;
      start = 1'b1;
      waitDone(cyc);
      checkOutput("b2b1_latency", 32'(cyc), 32'd8);
      checkResult("b2b1", 32'h0123_4567, 1'b0, 1'b0);
      tick();
      start = 1'b0;
      checkOutput("b2b_accept_ready", 32'(ready), 32'd0);
      waitDone(cyc);
      checkOutput("b2b2_latency", 32'(cyc), 32'd8);
      checkResult("b2b2", 32'h0, 1'b0, 1'b1);

      // Reset during the 4th RUN cycle aborts without a done
      applyStimulus(32'h8000_0000, 32'h1, 1'b0);
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done) seen++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("abort_ready", 32'(ready), 32'd1);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkResult("abort", 32'd0, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) seen++;
      end
      checkOutput("abort_no_done", 32'(seen), 32'd0);
      runCheck("sub_9_4", 32'h9, 32'h4, 1'b0, 32'h5, 1'b0, 1'b0);

      for (int n = 0; n < 1000; n++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) tick();
         ra  = $urandom;
         rb  = $urandom;
         rbi = 1'($urandom_range(0, 1));
         if (n % 50 == 0) rb = ra;
         m = refModel(ra, rb, rbi);
         runCheck("rand", ra, rb, rbi, m[31:0], m[33], m[32]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
